// File: rtl/red_serial_ctrl.sv
// red_serial_ctrl
// Serial byte-reduction (RED) unit. It adds four signed bytes,
// (a_lo + b_lo) + (a_hi + b_hi), using a single 4-bit carry-lookahead slice.
// The slice handles one nibble per cycle: two nibbles for each byte sum,
// then three nibbles for the 12-bit combine.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : request a new operation; only looked at while idle
//   a, b   : 16-bit operands, each holding two signed bytes {hi, lo}
//   busy   : high in every state except IDLE
//   done   : one-cycle pulse when result is updated
//   result : sign-extended 10-bit sum; held until the next operation finishes

// CLA_4bit
// Purely combinational 4-bit carry-lookahead adder slice.
//   x, y : nibble operands
//   cin  : carry in
//   sum  : nibble sum
//   cout : carry out of bit 3
module CLA_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Each carry is built from generate/propagate terms, not rippled from the
  // previous bit.
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

module red_serial_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LO0  = 4'd1,
    LO1  = 4'd2,
    HI0  = 4'd3,
    HI1  = 4'd4,
    CMB0 = 4'd5,
    CMB1 = 4'd6,
    CMB2 = 4'd7,
    DONE = 4'd8
  } state_t;

  state_t      state;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        carry;
  logic [8:0]  lo9;
  logic [8:0]  hi9;
  logic [7:0]  cmb;

  logic [3:0]  slice_x;
  logic [3:0]  slice_y;
  logic        slice_cin;
  logic [3:0]  slice_sum;
  logic        slice_cout;

  logic [11:0] ext_lo;
  logic [11:0] ext_hi;

  // Sign-extend both 9-bit byte sums to 12 bits. That width covers the full
  // range of the combine, whose true result fits in 10 bits.
  assign ext_lo = {{3{lo9[8]}}, lo9};
  assign ext_hi = {{3{hi9[8]}}, hi9};

  CLA_4bit u_slice (
    .x    (slice_x),
    .y    (slice_y),
    .cin  (slice_cin),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Choose the nibble pair for the current step. The first nibble of each
  // addition forces cin to zero. Later nibbles take the carry saved from the
  // previous step.
  always_comb begin
    slice_x   = 4'h0;
    slice_y   = 4'h0;
    slice_cin = 1'b0;
    unique case (state)
      LO0: begin
        slice_x = op_a[3:0];
        slice_y = op_b[3:0];
      end
      LO1: begin
        slice_x   = op_a[7:4];
        slice_y   = op_b[7:4];
        slice_cin = carry;
      end
      HI0: begin
        slice_x = op_a[11:8];
        slice_y = op_b[11:8];
      end
      HI1: begin
        slice_x   = op_a[15:12];
        slice_y   = op_b[15:12];
        slice_cin = carry;
      end
      CMB0: begin
        slice_x = ext_lo[3:0];
        slice_y = ext_hi[3:0];
      end
      CMB1: begin
        slice_x   = ext_lo[7:4];
        slice_y   = ext_hi[7:4];
        slice_cin = carry;
      end
      CMB2: begin
        slice_x   = ext_lo[11:8];
        slice_y   = ext_hi[11:8];
        slice_cin = carry;
      end
      default: begin
        slice_x   = 4'h0;
        slice_y   = 4'h0;
        slice_cin = 1'b0;
      end
    endcase
  end

  // Sequencer. busy and done are registered together with the state change,
  // so they never depend combinationally on start. The carry register
  // captures the slice carry-out on every arithmetic step.
  // For bit 8 of a byte sum, both bytes are sign-extended by one bit, so the
  // bit is a[7] ^ b[7] ^ (carry out of the high nibble).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      carry  <= 1'b0;
      lo9    <= 9'h000;
      hi9    <= 9'h000;
      cmb    <= 8'h00;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= LO0;
          end
        end
        LO0: begin
          lo9[3:0] <= slice_sum;
          carry    <= slice_cout;
          state    <= LO1;
        end
        LO1: begin
          lo9[7:4] <= slice_sum;
          lo9[8]   <= op_a[7] ^ op_b[7] ^ slice_cout;
          carry    <= slice_cout;
          state    <= HI0;
        end
        HI0: begin
          hi9[3:0] <= slice_sum;
          carry    <= slice_cout;
          state    <= HI1;
        end
        HI1: begin
          hi9[7:4] <= slice_sum;
          hi9[8]   <= op_a[15] ^ op_b[15] ^ slice_cout;
          carry    <= slice_cout;
          state    <= CMB0;
        end
        CMB0: begin
          cmb[3:0] <= slice_sum;
          carry    <= slice_cout;
          state    <= CMB1;
        end
        CMB1: begin
          cmb[7:4] <= slice_sum;
          carry    <= slice_cout;
          state    <= CMB2;
        end
        CMB2: begin
          // Bits 9:8 of the 10-bit result come from this nibble. Sign-extend
          // from bit 9 to get the 16-bit result.
          result <= {{6{slice_sum[1]}}, slice_sum[1:0], cmb};
          carry  <= slice_cout;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_red_serial_ctrl.sv
// tb_red_serial_ctrl
// Self-checking bench for red_serial_ctrl. At every rising edge a reference
// model decides whether start is accepted. When it is, the model pushes the
// expected result, computed as a plain signed sum of four bytes. A monitor on
// the falling edge checks busy and done against the model's countdown of the
// eight busy cycles. On each DUT done pulse it pops one expected result and
// checks that result holds that value until the next pulse.
module tb_red_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int          model_cnt = 0;
  logic [15:0] exp_q[$];
  int          rst_gen = 0;
  int          seen_gen = 0;
  logic [15:0] held = 16'h0000;

  red_serial_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Compare one value against its expectation and count the outcome.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual,
               expected, cyc);
    end
  endtask

  // Reference result: the exact signed sum of four bytes, truncated to 16 bits.
  function automatic logic [15:0] red_ref(input logic [15:0] x,
                                          input logic [15:0] y);
    int s;
    s = int'($signed(x[7:0])) + int'($signed(x[15:8]))
      + int'($signed(y[7:0])) + int'($signed(y[15:8]));
    return s[15:0];
  endfunction

  // Random byte, biased toward the boundary values 7F, 80, FF and 00.
  function automatic logic [7:0] pick_byte();
    logic [7:0] v;
    case ($urandom % 6)
      0: v = 8'h7F;
      1: v = 8'h80;
      2: v = 8'hFF;
      3: v = 8'h00;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Behavioural model of acceptance. start is accepted only when no
  // operation is in flight. Each accepted operation stays busy for eight
  // cycles, and the last of those cycles is the done cycle.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_cnt = 0;
      exp_q.delete();
      rst_gen++;
    end else if (model_cnt == 0) begin
      if (start) begin
        model_cnt = 8;
        exp_q.push_back(red_ref(a, b));
      end
    end else begin
      model_cnt--;
    end
  end

  // Monitor. Checks handshakes against the model. On each done pulse it pops
  // the oldest expected result, and it checks that result holds steady.
  always @(negedge clk) begin
    if (rst_gen != seen_gen) begin
      held     = 16'h0000;
      seen_gen = rst_gen;
    end
    checkOutput("busy", 16'(busy), 16'(model_cnt > 0));
    checkOutput("done", 16'(done), 16'(model_cnt == 1));
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL done_unexpected: got done=1, expected no pending op (cycle %0d)", cyc);
      end else begin
        held = exp_q.pop_front();
      end
    end
    checkOutput("result", result, held);
  end

  // Issue one operation from IDLE, wait for done with a bound, and check the
  // latency from the start cycle to the done cycle.
  task automatic applyStimulus(input logic [15:0] xa, input logic [15:0] xb);
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = xa;
    b     = xb;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    lat   = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 16'(lat), 16'd8);
  endtask

  logic [15:0] dir_a[5] = '{16'h0102, 16'h7F7F, 16'h8080, 16'hFF01, 16'h0F0F};
  logic [15:0] dir_b[5] = '{16'h0304, 16'h7F7F, 16'h8080, 16'h00FF, 16'h0101};
  logic [15:0] dir_r[5] = '{16'h000A, 16'h01FC, 16'hFE00, 16'hFFFF, 16'h0020};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    checkOutput("reset_done", 16'(done), 16'd0);
    checkOutput("reset_result", result, 16'h0000);
    rst_n = 1'b1;

    // Directed operands with hand-computed results.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(dir_a[i], dir_b[i]);
      checkOutput("directed_result", result, dir_r[i]);
    end

    // Hold start high with changing operands. Only IDLE accepts it.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Reset while the sequencer is in HI1 (four edges after acceptance).
    @(negedge clk);
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_busy", 16'(busy), 16'd0);
    checkOutput("midreset_done", 16'(done), 16'd0);
    checkOutput("midreset_result", result, 16'h0000);
    repeat (12) @(negedge clk);
    applyStimulus(16'h0F0F, 16'h0101);
    checkOutput("post_reset_result", result, 16'h0020);

    // Random regression: random start pulses, boundary-biased operands and
    // rare resets.
    for (int i = 0; i < 25000; i++) begin
      start = ($urandom % 3) == 0;
      a     = {pick_byte(), pick_byte()};
      b     = {pick_byte(), pick_byte()};
      rst_n = ($urandom % 700) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net in case the bench ever stops making progress.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 2000000 ns");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
